// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN enables data-dependent early completion.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [4:0]       in_rd_addr,
    input  logic [TAG_W-1:0] in_instr_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       wb_rd_addr,
    output logic             wb_rd_wr_en,
    output logic [TAG_W-1:0] wb_instr_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [4:0]        rd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   result;

    logic              a_signed, b_signed, sign_a, sign_b, res_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, sdiv_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     partial, diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;
    logic              last_step;

    assign in_ready     = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign out_valid    = (state == S_DONE);
    assign wb_data      = result;
    assign wb_rd_addr   = rd_q;
    assign wb_instr_tag = tag_q;
    assign wb_rd_wr_en  = out_valid && (rd_q != 5'd0);

    // Operands are reduced to unsigned magnitudes; the result sign is re-applied at the end.
    always_comb begin
        a_signed    = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        b_signed    = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        sign_a      = a_signed && in_rs1_data[XLEN-1];
        sign_b      = b_signed && in_rs2_data[XLEN-1];
        mag_a       = sign_a ? -in_rs1_data : in_rs1_data;
        mag_b       = sign_b ? -in_rs2_data : in_rs2_data;
        res_neg     = (in_op[2] && in_op[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero    = in_op[2] && (in_rs2_data == '0);
        sdiv_ovf    = in_op[2] && !in_op[0] && (in_rs1_data == MIN_NEG) && (in_rs2_data == '1);
        special     = div_zero || sdiv_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = in_op[1] ? in_rs1_data : '1;
        end else if (sdiv_ovf) begin
            special_res = in_op[1] ? '0 : in_rs1_data;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (in_op[2] && (mag_a < mag_b)) begin
            special     = 1'b1;
            special_res = in_op[1] ? in_rs1_data : '0;
        end else if (!in_op[2] && (mag_b == '0)) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

    // Divide keeps {remainder, quotient} in acc and shifts the dividend in MSB-first.
    always_comb begin
        partial = acc[2*XLEN-1:XLEN-1];
        diff    = partial - {1'b0, opb};
        if (op_q[2]) begin
            if (diff[XLEN]) begin
                acc_next = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = opb[0] ? (acc + mcand) : acc;
        end

        prod = neg_q ? -acc_next : acc_next;
        quo  = acc_next[XLEN-1:0];
        rem  = acc_next[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            if (op_q[1]) begin
                final_res = neg_q ? -rem : rem;
            end else begin
                final_res = neg_q ? -quo : quo;
            end
        end else if (op_q[1:0] == 2'd0) begin
            final_res = prod[XLEN-1:0];
        end else begin
            final_res = prod[2*XLEN-1:XLEN];
        end

`ifdef MULDIV_EARLY_OUT_EN
        last_step = (cnt == '0) || (!op_q[2] && (opb[XLEN-1:1] == '0));
`else
        last_step = (cnt == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rd_q   <= '0;
            tag_q  <= '0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_op;
                        neg_q <= res_neg;
                        rd_q  <= in_rd_addr;
                        tag_q <= in_instr_tag;
                        if (special) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else begin
                            acc   <= in_op[2] ? {{XLEN{1'b0}}, mag_a} : '0;
                            mcand <= {{XLEN{1'b0}}, mag_a};
                            opb   <= mag_b;
                            cnt   <= CW'(XLEN - 1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    mcand <= {mcand[2*XLEN-2:0], 1'b0};
                    opb   <= op_q[2] ? opb : {1'b0, opb[XLEN-1:1]};
                    cnt   <= cnt - 1'b1;
                    if (last_step) begin
                        result <= final_res;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, corner cases, flush/reset and back-pressure.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_instr_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wr_en;
    logic [31:0] wb_instr_tag;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] tag;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rd_addr(in_rd_addr), .in_instr_tag(in_instr_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_rd_wr_en(wb_rd_wr_en),
        .wb_instr_tag(wb_instr_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic built on 64-bit host math.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (!op[2]) return (op == 3'd0) ? p[31:0] : p[63:32];
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Edges counted from the accept edge (inclusive) until out_valid is seen.
    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] ma, mb;
        ma = ((op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) && a[31]) ? -a : a;
        mb = ((op == 3'd1 || op == 3'd4 || op == 3'd6) && b[31]) ? -b : b;
`endif
        if (op[2] && b == 32'd0) return 1;
        if (!op[0] && op[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2]) return (ma < mb) ? 1 : 33;
        if (mb == 32'd0) return 1;
        for (int i = 31; i >= 0; i--) if (mb[i]) return i + 2;
`endif
        return 33;
    endfunction

    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] tag);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_op = op; in_rs1_data = a; in_rs2_data = b; in_rd_addr = rd; in_instr_tag = tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] tag, input logic [31:0] exp_data);
        exp_t e;
        e.data = exp_data; e.rd = rd; e.tag = tag; e.lat = model_latency(op, a, b);
        sb.push_back(e);
        startOp(op, a, b, rd, tag);
    endtask

    task automatic checkOutput(input string tag, input int hold);
        exp_t e;
        int lat = 1;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_data"}, 64'(wb_data), 64'(e.data));
        check({tag, "_rd"}, 64'(wb_rd_addr), 64'(e.rd));
        check({tag, "_tag"}, 64'(wb_instr_tag), 64'(e.tag));
        check({tag, "_wr_en"}, 64'(wb_rd_wr_en), 64'(e.rd != 5'd0));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(wb_data), 64'(e.data));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
        check({tag, "_wb_rd"}, 64'(wb_rd_addr), 64'd0);
        check({tag, "_wb_wr_en"}, 64'(wb_rd_wr_en), 64'd0);
        check({tag, "_wb_tag"}, 64'(wb_instr_tag), 64'd0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        seen;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1_data = '0; in_rs2_data = '0;
        in_rd_addr = '0; in_instr_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'h100, 32'hFFFF_FFEB);
        checkOutput("mul", 0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h104, 32'h4000_0000);
        checkOutput("mulh", 0);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h108, 32'hFFFF_FFFE);
        checkOutput("mulhu", 0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h10C, 32'hFFFF_FFFF);
        checkOutput("mulhsu", 0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'h110, 32'hFFFF_FFFD);
        checkOutput("div_neg", 0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h114, 32'hFFFF_FFFF);
        checkOutput("rem_neg", 0);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd7, 32'h118, 32'd14);
        checkOutput("divu", 0);
        applyStimulus(3'd7, 32'd100, 32'd7, 5'd8, 32'h11C, 32'd2);
        checkOutput("remu", 0);
        applyStimulus(3'd5, 32'd5, 32'd0, 5'd9, 32'h120, 32'hFFFF_FFFF);
        checkOutput("divu_by_zero", 0);
        applyStimulus(3'd6, 32'd5, 32'd0, 5'd10, 32'h124, 32'd5);
        checkOutput("rem_by_zero", 0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h128, 32'h8000_0000);
        checkOutput("div_ovf", 0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h12C, 32'd0);
        checkOutput("rem_ovf", 0);
        applyStimulus(3'd0, 32'h1234, 32'd3, 5'd13, 32'h130, 32'h369C);
        checkOutput("mul_small", 0);
        applyStimulus(3'd5, 32'd3, 32'd10, 5'd14, 32'h134, 32'd0);
        checkOutput("divu_small", 0);

        applyStimulus(3'd0, 32'd9, 32'd9, 5'd15, 32'h138, 32'd81);
        checkOutput("backpressure", 5);
        applyStimulus(3'd4, 32'd50, 32'd5, 5'd0, 32'h13C, 32'd10);
        checkOutput("rd_zero", 0);

        // Flush ten cycles into CALC: nothing may come out afterwards.
        startOp(3'd0, 32'd11, 32'hFFFF_FFFF, 5'd3, 32'h200);
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        in_op = 3'd5; in_rs1_data = 32'd8; in_rs2_data = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept_busy", 64'(busy), 64'd0);
        check("flush_vs_accept_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = (i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
            applyStimulus(r_op, r_a, r_b, 5'(i + 16), 32'h300 + 32'(i), model_result(r_op, r_a, r_b));
            checkOutput("random", 0);
        end

        // Reset pulse in the middle of a computation.
        startOp(3'd5, 32'hFFFF_0000, 32'd3, 5'd21, 32'h400);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("reset_mid_calc");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("reset_no_result", 64'(seen), 64'd0);

        applyStimulus(3'd7, 32'hFFFF_FFFF, 32'd16, 5'd22, 32'h500, 32'd15);
        checkOutput("after_reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
